// File: rtl/lcd_pkg.sv
// Shared constants, instruction classes and address helpers for the
// HD44780-compatible LCD responder.
package lcd_pkg;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE2_END  = 7'h67;

  localparam logic [7:0]  CHAR_SPACE  = 8'h20;
  localparam int unsigned LINE_LEN    = 40;
  localparam int unsigned DDRAM_DEPTH = 80;

  typedef enum logic [2:0] {
    CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM
  } instr_class_e;

  // Instruction class from the highest set bit; 0x00 has no effect beyond busy.
  function automatic instr_class_e instr_class(input logic [7:0] d);
    instr_class_e c;
    casez (d)
      8'b1???????: c = DDRAM;
      8'b01??????: c = CGRAM;
      8'b001?????: c = FUNC;
      8'b0001????: c = SHIFT;
      8'b00001???: c = DISP;
      8'b000001??: c = ENTRY;
      8'b0000001?: c = HOME;
      8'b00000001: c = CLR;
      default:     c = CGRAM;
    endcase
    return c;
  endfunction

  // Address counter step with line wrap in both directions.
  function automatic logic [6:0] ac_next(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if (a == LINE1_END)      n = LINE2_BASE;
      else if (a == LINE2_END) n = LINE1_BASE;
      else                     n = a + 7'd1;
    end else begin
      if (a == LINE2_BASE)     n = LINE1_END;
      else if (a == LINE1_BASE) n = LINE2_END;
      else                     n = a - 7'd1;
    end
    return n;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
  endfunction

  // Storage index = line * 40 + column.
  function automatic logic [6:0] ddram_index(input logic [6:0] a);
    return a[6] ? (7'(LINE_LEN) + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one synchronous write port, two combinational
// read ports (address-counter side and debug side). Addresses are storage
// indices 0..79; out-of-range reads return 0.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] ac_addr,
  output logic [7:0] ac_data,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic [7:0] mem [DDRAM_DEPTH];

  // Single write port shared by clear-fill and data writes
  always_ff @(posedge clk) begin
    if (we && (waddr < 7'(DDRAM_DEPTH))) mem[waddr] <= wdata;
  end

  assign ac_data  = (ac_addr  < 7'(DDRAM_DEPTH)) ? mem[ac_addr]  : '0;
  assign dbg_data = (dbg_addr < 7'(DDRAM_DEPTH)) ? mem[dbg_addr] : '0;

endmodule

// File: rtl/lcd_responder.sv
// HD44780-compatible character-LCD responder: decodes falling-edge strobes
// on en, maintains DDRAM, address counter, display flags and busy timing.
// Optional feature macro: LCD_READBACK_EN enables the bus read path.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2_000,
  parameter int unsigned CLEAR_CYCLES = 40_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic       overrun,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic [6:0] ac,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char
);

  localparam logic [31:0] FILL_LEN = 32'(DDRAM_DEPTH);
  localparam logic [6:0]  FILL_END = 7'(DDRAM_DEPTH - 1);

  logic         en_q;
  logic         strobe;
  logic [31:0]  busy_cnt;
  logic         fill_active;
  logic [6:0]   fill_idx;
  logic         inc_mode, shift_mode, dl_mode, font_mode;
  logic         we;
  logic [6:0]   waddr;
  logic [7:0]   wdata;
  logic [7:0]   ac_char;
  logic [7:0]   dbg_raw;
  logic         unused_bits;
  instr_class_e cls;

  assign strobe = en_q & ~en;
  assign busy   = (busy_cnt != '0);
  assign cls    = instr_class(data_in);

  lcd_ddram u_ddram (
    .clk      (clk),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .ac_addr  (ddram_index(ac)),
    .ac_data  (ac_char),
    .dbg_addr (ddram_index(dbg_addr)),
    .dbg_data (dbg_raw)
  );

  assign dbg_char = addr_valid(dbg_addr) ? dbg_raw : '0;

  // DDRAM write mux: fill owns the port while active (always busy then)
  always_comb begin
    we    = 1'b0;
    waddr = fill_idx;
    wdata = CHAR_SPACE;
    if (!rst) begin
      if (fill_active) begin
        we = 1'b1;
      end else if (strobe && rs && !rw && !busy) begin
        we    = 1'b1;
        waddr = ddram_index(ac);
        wdata = data_in;
      end
    end
  end

  // Strobe decode, address counter, flags, busy counter and clear fill
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      busy_cnt    <= FILL_LEN;
      fill_active <= 1'b1;
      fill_idx    <= '0;
      overrun     <= 1'b0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      ac          <= '0;
      inc_mode    <= 1'b1;
      shift_mode  <= 1'b0;
      dl_mode     <= 1'b0;
      font_mode   <= 1'b0;
    end else begin
      en_q <= en;
      if (busy_cnt != '0) busy_cnt <= busy_cnt - 32'd1;
      if (fill_active) begin
        fill_idx <= fill_idx + 7'd1;
        if (fill_idx == FILL_END) fill_active <= 1'b0;
      end
      if (strobe && !rw) begin
        if (busy) begin
          overrun <= 1'b1;
        end else if (rs) begin
          ac       <= ac_next(ac, inc_mode);
          busy_cnt <= 32'(BUSY_CYCLES);
        end else begin
          busy_cnt <= 32'(BUSY_CYCLES);
          unique case (cls)
            CLR: begin
              fill_active <= 1'b1;
              fill_idx    <= '0;
              ac          <= '0;
              inc_mode    <= 1'b1;
              busy_cnt    <= 32'(CLEAR_CYCLES);
            end
            HOME: begin
              ac       <= '0;
              busy_cnt <= 32'(CLEAR_CYCLES);
            end
            ENTRY: begin
              inc_mode   <= data_in[1];
              shift_mode <= data_in[0];
            end
            DISP: begin
              display_on <= data_in[2];
              cursor_on  <= data_in[1];
              blink_on   <= data_in[0];
            end
            SHIFT: begin
              if (!data_in[3]) ac <= ac_next(ac, data_in[2]);
            end
            FUNC: begin
              dl_mode   <= data_in[4];
              two_line  <= data_in[3];
              font_mode <= data_in[2];
            end
            CGRAM: begin
            end
            DDRAM: begin
              ac <= addr_valid(data_in[6:0]) ? data_in[6:0] : LINE1_BASE;
            end
          endcase
        end
      end
`ifdef LCD_READBACK_EN
      // Data reads advance AC only when idle; status reads never do
      if (strobe && rw && rs && !busy) ac <= ac_next(ac, inc_mode);
`endif
    end
  end

`ifdef LCD_READBACK_EN
  // Registered read data, valid whenever en and rw are both high
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      data_oe  <= en & rw;
      data_out <= !(en & rw) ? '0 : (rs ? ac_char : {busy, ac});
    end
  end
  assign unused_bits = ^{shift_mode, dl_mode, font_mode};
`else
  assign data_out    = '0;
  assign data_oe     = 1'b0;
  assign unused_bits = ^{shift_mode, dl_mode, font_mode, ac_char};
`endif

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder. DDRAM expectations go through a
// scoreboard queue and are drained through the debug read port.
module tb_lcd_responder;

  localparam int unsigned BUSY_N  = 20;
  localparam int unsigned CLEAR_N = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_oe, busy, overrun, display_on, cursor_on, blink_on, two_line;
  logic [6:0] ac;
  logic [6:0] dbg_addr = '0;
  logic [7:0] dbg_char;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string      name;
    logic [6:0] addr;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];

  lcd_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rs         (rs),
    .rw         (rw),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .busy       (busy),
    .overrun    (overrun),
    .display_on (display_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .two_line   (two_line),
    .ac         (ac),
    .dbg_addr   (dbg_addr),
    .dbg_char   (dbg_char)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full en pulse; strobe effects are visible on return
  task automatic bus_write(input logic r, input logic [7:0] d);
    en = 1'b1; rs = r; rw = 1'b0; data_in = d;
    tick();
    en = 1'b0;
    tick();
  endtask

  task automatic busy_len(output int unsigned n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    busy_len(n);
    if (busy !== 1'b0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: busy timeout actual=%b required=0", tag, busy);
    end
  endtask

  task automatic send(input logic r, input logic [7:0] d, input string tag);
    bus_write(r, d);
    wait_idle(tag);
  endtask

  task automatic test_reset();
    int unsigned n;
    sb_t e;
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({busy, overrun, display_on, cursor_on, blink_on, two_line, data_oe} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_flags: actual=%b required=1000000",
               {busy, overrun, display_on, cursor_on, blink_on, two_line, data_oe});
    end
    tests_run++;
    if (ac !== 7'h00 || data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ac_data: actual ac=%h data_out=%h required 00/00", ac, data_out);
    end
    rst = 1'b0;
    busy_len(n);
    tests_run++;
    if (n != 80) begin
      tests_failed++;
      $display("FAIL reset_fill_len: actual=%0d required=80", n);
    end
    sb.push_back('{"reset_fill", 7'h00, 8'h20});
    sb.push_back('{"reset_fill", 7'h27, 8'h20});
    sb.push_back('{"reset_fill", 7'h40, 8'h20});
    sb.push_back('{"reset_fill", 7'h67, 8'h20});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_addr = e.addr;
      #1;
      tests_run++;
      if (dbg_char !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: ddram[%h] actual=%h required=%h", e.name, e.addr, dbg_char, e.exp);
      end
    end
    tests_run++;
    if (ac !== 7'h00) begin
      tests_failed++;
      $display("FAIL reset_ac_after_fill: actual=%h required=00", ac);
    end
  endtask

  task automatic test_text();
    int unsigned n;
    sb_t e;
    logic [7:0] txt [5] = '{8'h43, 8'h4C, 8'h45, 8'h41, 8'h52};
    send(1'b0, 8'h38, "func_set");
    bus_write(1'b0, 8'h0E);
    busy_len(n);
    tests_run++;
    if (n != BUSY_N) begin
      tests_failed++;
      $display("FAIL busy_len: actual=%0d required=%0d", n, BUSY_N);
    end
    bus_write(1'b0, 8'h01);
    busy_len(n);
    tests_run++;
    if (n != CLEAR_N) begin
      tests_failed++;
      $display("FAIL clear_busy_len: actual=%0d required=%0d", n, CLEAR_N);
    end
    send(1'b0, 8'h02, "home");
    send(1'b0, 8'h06, "entry");
    for (int i = 0; i < 5; i++) begin
      send(1'b1, txt[i], "text");
      sb.push_back('{"text", 7'(i), txt[i]});
    end
    tests_run++;
    if (ac !== 7'h05) begin
      tests_failed++;
      $display("FAIL text_ac: actual=%h required=05", ac);
    end
    tests_run++;
    if ({two_line, display_on, cursor_on, blink_on, overrun} !== 5'b11100) begin
      tests_failed++;
      $display("FAIL text_flags: actual=%b required=11100",
               {two_line, display_on, cursor_on, blink_on, overrun});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_addr = e.addr;
      #1;
      tests_run++;
      if (dbg_char !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: ddram[%h] actual=%h required=%h", e.name, e.addr, dbg_char, e.exp);
      end
    end
  endtask

  task automatic test_line_wrap();
    sb_t e;
    logic [7:0] cmds [6] = '{8'hA7, 8'h41, 8'h42, 8'hE7, 8'h43, 8'h85};
    logic       rsel [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] acx  [6] = '{7'h27, 7'h40, 7'h41, 7'h67, 7'h00, 7'h05};
    for (int i = 0; i < 6; i++) begin
      send(rsel[i], cmds[i], "wrap");
      tests_run++;
      if (ac !== acx[i]) begin
        tests_failed++;
        $display("FAIL wrap_ac_%0d: actual=%h required=%h", i, ac, acx[i]);
      end
    end
    send(1'b0, 8'hB0, "bad_addr");
    tests_run++;
    if (ac !== 7'h00) begin
      tests_failed++;
      $display("FAIL invalid_addr_ac: actual=%h required=00", ac);
    end
    sb.push_back('{"wrap", 7'h27, 8'h41});
    sb.push_back('{"wrap", 7'h40, 8'h42});
    sb.push_back('{"wrap", 7'h67, 8'h43});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_addr = e.addr;
      #1;
      tests_run++;
      if (dbg_char !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: ddram[%h] actual=%h required=%h", e.name, e.addr, dbg_char, e.exp);
      end
    end
  endtask

  task automatic test_decrement();
    sb_t e;
    logic [7:0] cmds [7] = '{8'h04, 8'h80, 8'h5A, 8'hC0, 8'h5B, 8'h14, 8'h10};
    logic       rsel [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [6:0] acx  [7] = '{7'h00, 7'h00, 7'h67, 7'h40, 7'h27, 7'h40, 7'h27};
    send(1'b0, 8'h80, "dec_pre");
    for (int i = 0; i < 7; i++) begin
      send(rsel[i], cmds[i], "dec");
      tests_run++;
      if (ac !== acx[i]) begin
        tests_failed++;
        $display("FAIL dec_ac_%0d: actual=%h required=%h", i, ac, acx[i]);
      end
    end
    send(1'b0, 8'h18, "shift_noop");
    tests_run++;
    if (ac !== 7'h27) begin
      tests_failed++;
      $display("FAIL shift_noop_ac: actual=%h required=27", ac);
    end
    send(1'b0, 8'h06, "restore_inc");
    sb.push_back('{"dec", 7'h00, 8'h5A});
    sb.push_back('{"dec", 7'h40, 8'h5B});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_addr = e.addr;
      #1;
      tests_run++;
      if (dbg_char !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: ddram[%h] actual=%h required=%h", e.name, e.addr, dbg_char, e.exp);
      end
    end
  endtask

  task automatic test_readback();
    send(1'b0, 8'h80, "rd_addr");
    bus_write(1'b0, 8'h0C);
    en = 1'b1; rs = 1'b0; rw = 1'b1;
    tick();
`ifdef LCD_READBACK_EN
    tests_run++;
    if (data_oe !== 1'b1 || data_out !== 8'h80) begin
      tests_failed++;
      $display("FAIL status_read: actual oe=%b data=%h required oe=1 data=80", data_oe, data_out);
    end
`else
    tests_run++;
    if (data_oe !== 1'b0 || data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL status_read_off: actual oe=%b data=%h required oe=0 data=00", data_oe, data_out);
    end
`endif
    en = 1'b0;
    tick();
    rw = 1'b0;
    tests_run++;
    if (ac !== 7'h00 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_busy_side: actual ac=%h ovr=%b required ac=00 ovr=0", ac, overrun);
    end
    wait_idle("rd_idle");
    en = 1'b1; rs = 1'b1; rw = 1'b1;
    tick();
`ifdef LCD_READBACK_EN
    tests_run++;
    if (data_oe !== 1'b1 || data_out !== 8'h5A) begin
      tests_failed++;
      $display("FAIL data_read: actual oe=%b data=%h required oe=1 data=5a", data_oe, data_out);
    end
`else
    tests_run++;
    if (data_oe !== 1'b0 || data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL data_read_off: actual oe=%b data=%h required oe=0 data=00", data_oe, data_out);
    end
`endif
    en = 1'b0;
    tick();
    rw = 1'b0;
    tests_run++;
`ifdef LCD_READBACK_EN
    if (ac !== 7'h01) begin
      tests_failed++;
      $display("FAIL data_read_ac: actual=%h required=01", ac);
    end
`else
    if (ac !== 7'h00) begin
      tests_failed++;
      $display("FAIL data_read_ac_off: actual=%h required=00", ac);
    end
`endif
  endtask

  task automatic test_overrun();
    sb_t e;
    bus_write(1'b0, 8'h01);
    bus_write(1'b1, 8'h41);
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: actual=%b required=1", overrun);
    end
    wait_idle("ovr_idle");
    tests_run++;
    if (ac !== 7'h00 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_after: actual ac=%h ovr=%b required ac=00 ovr=1", ac, overrun);
    end
    sb.push_back('{"ovr_fill", 7'h00, 8'h20});
    sb.push_back('{"ovr_fill", 7'h27, 8'h20});
    sb.push_back('{"ovr_fill", 7'h40, 8'h20});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      dbg_addr = e.addr;
      #1;
      tests_run++;
      if (dbg_char !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: ddram[%h] actual=%h required=%h", e.name, e.addr, dbg_char, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int unsigned n;
    send(1'b1, 8'h5A, "pre_rst_write");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_fill_flags: actual ovr=%b busy=%b required ovr=0 busy=1", overrun, busy);
    end
    rst = 1'b0;
    busy_len(n);
    tests_run++;
    if (n != 80) begin
      tests_failed++;
      $display("FAIL rst_mid_fill_len: actual=%0d required=80", n);
    end
    dbg_addr = 7'h00;
    #1;
    tests_run++;
    if (dbg_char !== 8'h20) begin
      tests_failed++;
      $display("FAIL rst_mid_fill_ddram: actual=%h required=20", dbg_char);
    end
  endtask

  initial begin
    test_reset();
    test_text();
    test_line_wrap();
    test_decrement();
    test_readback();
    test_overrun();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
